// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// EX/MEM boundary stage that sits right after the branch driver. The front end
// fetches with a static not-taken policy; this stage decides whether the
// instruction in EX actually changes control flow, and if so fires a one-cycle
// PC redirect plus front-end flush. The next SQUASH_N valid instructions that
// still reach EX come from the wrong path, so they are turned into MEM bubbles.
// The surviving instruction is registered into MEM, and two saturating
// counters track how many branches were resolved and how many redirects fired.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   stall              MEM not ready; the whole stage holds
//   ex_valid           EX holds a real instruction
//   ex_branch/jal/jalr control class of the EX instruction (jalr > jal > branch)
//   ex_pc, ex_imm      PC and sign-extended immediate of the EX instruction
//   ex_result          ALU result from the branch driver (rs1+imm for JALR)
//   ex_rd, ex_regwrite destination register and its write enable
//   mem_*              registered MEM stage instruction
//   pc_redirect        one-cycle pulse: fetch from redirect_target
//   redirect_target    new PC, meaningful only while pc_redirect=1
//   flush_front        kills IF/ID and ID/EX, same timing as pc_redirect
//   target_misaligned  pulses with pc_redirect when the target is not word aligned
//   branch_cnt         conditional branches resolved (saturating)
//   taken_cnt          redirects issued (saturating)
// -----------------------------------------------------------------------------
module branch_resolve #(
  parameter int SQUASH_N = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_result,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  output logic             mem_valid,
  output logic [31:0]      mem_result,
  output logic [4:0]       mem_rd,
  output logic             mem_regwrite,
  output logic             pc_redirect,
  output logic [31:0]      redirect_target,
  output logic             flush_front,
  output logic             target_misaligned,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {
    RUN,
    SQUASH
  } state_t;

  state_t      state;
  logic [2:0]  squash_cnt;

  logic        accept;
  logic        sel_jalr;
  logic        sel_jal;
  logic        sel_branch;
  logic        taken;
  logic        redirect;
  logic        resolve_branch;
  logic [31:0] target;
  logic [31:0] link_addr;

  // Decode the EX instruction. Illegal combinations of control bits are
  // resolved by priority so that exactly one source (or none) is selected;
  // a branch only counts as a branch when nothing outranks it.
  always_comb begin
    accept         = 1'b0;
    sel_jalr       = 1'b0;
    sel_jal        = 1'b0;
    sel_branch     = 1'b0;
    taken          = 1'b0;
    redirect       = 1'b0;
    resolve_branch = 1'b0;
    target         = 32'h0;
    link_addr      = 32'h0;

    accept     = !stall && ex_valid;
    sel_jalr   = ex_jalr;
    sel_jal    = !ex_jalr && ex_jal;
    sel_branch = !ex_jalr && !ex_jal && ex_branch;

    // The driver reports a taken branch as any nonzero result, including
    // the all-ones pattern it produces for BNE.
    taken = sel_branch && (ex_result != 32'h0);

    redirect       = accept && (state == RUN) && (taken || sel_jal || sel_jalr);
    resolve_branch = accept && (state == RUN) && sel_branch;

    if (sel_jalr) begin
      target = {ex_result[31:1], 1'b0};
    end else begin
      target = ex_pc + ex_imm;
    end
    link_addr = ex_pc + 32'd4;
  end

  // Stage FSM. The redirect outputs are rebuilt every edge regardless of
  // stall so the pulse is always exactly one cycle wide. MEM registers, the
  // state and the squash counter only move on unstalled edges. Bubbles keep
  // the old result and rd so downstream sees no spurious data toggling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RUN;
      squash_cnt        <= 3'd0;
      mem_valid         <= 1'b0;
      mem_result        <= 32'h0;
      mem_rd            <= 5'd0;
      mem_regwrite      <= 1'b0;
      pc_redirect       <= 1'b0;
      flush_front       <= 1'b0;
      redirect_target   <= 32'h0;
      target_misaligned <= 1'b0;
    end else begin
      pc_redirect       <= redirect;
      flush_front       <= redirect;
      redirect_target   <= redirect ? target : 32'h0;
      target_misaligned <= redirect && (target[1:0] != 2'b00);

      if (!stall) begin
        if (!ex_valid) begin
          mem_valid    <= 1'b0;
          mem_regwrite <= 1'b0;
        end else begin
          case (state)
            RUN: begin
              mem_valid    <= 1'b1;
              mem_rd       <= ex_rd;
              mem_regwrite <= ex_regwrite && !sel_branch;
              mem_result   <= (sel_jal || sel_jalr) ? link_addr : ex_result;
              if (redirect) begin
                squash_cnt <= 3'(SQUASH_N);
                state      <= SQUASH;
              end
            end
            SQUASH: begin
              mem_valid    <= 1'b0;
              mem_regwrite <= 1'b0;
              squash_cnt   <= squash_cnt - 3'd1;
              if (squash_cnt == 3'd1) begin
                state <= RUN;
              end
            end
            default: begin
              state <= RUN;
            end
          endcase
        end
      end
    end
  end

  // Saturating statistics: stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      if (resolve_branch && (branch_cnt != {CNT_W{1'b1}})) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (redirect && (taken_cnt != {CNT_W{1'b1}})) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//
// Drives branch_resolve with directed scenarios followed by randomized traffic.
// Two instances share the same stimulus: one with 16-bit counters and one with
// 2-bit counters so saturation can be seen quickly. A behavioural model tracks
// "how many wrong-path instructions are still to be dropped" as a plain integer
// and predicts every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_result;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;

  logic        mem_valid, mem_regwrite, pc_redirect, flush_front, target_misaligned;
  logic [31:0] mem_result, redirect_target;
  logic [4:0]  mem_rd;
  logic [15:0] branch_cnt, taken_cnt;

  logic        mem_valid2, mem_regwrite2, pc_redirect2, flush_front2, target_misaligned2;
  logic [31:0] mem_result2, redirect_target2;
  logic [4:0]  mem_rd2;
  logic [1:0]  branch_cnt2, taken_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_resolve #(.SQUASH_N(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .pc_redirect(pc_redirect),
    .redirect_target(redirect_target), .flush_front(flush_front),
    .target_misaligned(target_misaligned),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve #(.SQUASH_N(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .mem_valid(mem_valid2), .mem_result(mem_result2), .mem_rd(mem_rd2),
    .mem_regwrite(mem_regwrite2), .pc_redirect(pc_redirect2),
    .redirect_target(redirect_target2), .flush_front(flush_front2),
    .target_misaligned(target_misaligned2),
    .branch_cnt(branch_cnt2), .taken_cnt(taken_cnt2)
  );

  // Behavioural model state: expected outputs plus the number of wrong-path
  // instructions still to drop (0 means the stage is running normally).
  bit          started = 0;
  int          drop_left;
  bit          e_mvalid, e_rw, e_redir, e_mis;
  logic [31:0] e_res, e_target;
  logic [4:0]  e_rd;
  int          e_bcnt, e_tcnt, e_bcnt2, e_tcnt2;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, updated on every rising edge from the inputs that
  // were stable before that edge.
  always @(posedge clk) begin
    bit          acc, is_jump, is_br, redir;
    logic [31:0] tgt;
    if (reset) begin
      started  = 1;
      drop_left = 0;
      e_mvalid = 0; e_rw = 0; e_redir = 0; e_mis = 0;
      e_res = 0; e_target = 0; e_rd = 0;
      e_bcnt = 0; e_tcnt = 0; e_bcnt2 = 0; e_tcnt2 = 0;
    end else if (started) begin
      acc     = !stall && ex_valid;
      is_jump = ex_jal || ex_jalr;
      is_br   = ex_branch && !is_jump;
      redir   = acc && (drop_left == 0) && (is_jump || (is_br && ex_result != 0));
      tgt     = ex_jalr ? (ex_result & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
      e_redir  = redir;
      e_target = tgt;
      e_mis    = redir && (tgt % 4 != 0);
      if (!stall) begin
        if (ex_valid && drop_left == 0) begin
          e_mvalid = 1;
          e_rd     = ex_rd;
          e_rw     = ex_regwrite && !is_br;
          e_res    = is_jump ? ex_pc + 32'd4 : ex_result;
          if (is_br) begin
            e_bcnt  = (e_bcnt  < 65535) ? e_bcnt + 1  : e_bcnt;
            e_bcnt2 = (e_bcnt2 < 3)     ? e_bcnt2 + 1 : e_bcnt2;
          end
        end else begin
          e_mvalid = 0;
          e_rw     = 0;
          if (ex_valid) drop_left--;
        end
        if (redir) begin
          drop_left = 2;
          e_tcnt  = (e_tcnt  < 65535) ? e_tcnt + 1  : e_tcnt;
          e_tcnt2 = (e_tcnt2 < 3)     ? e_tcnt2 + 1 : e_tcnt2;
        end
      end
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("mdl mem_valid", {31'b0, mem_valid}, {31'b0, e_mvalid});
      checkOutput("mdl mem_regwrite", {31'b0, mem_regwrite}, {31'b0, e_rw});
      checkOutput("mdl mem_rd", {27'b0, mem_rd}, {27'b0, e_rd});
      checkOutput("mdl mem_result", mem_result, e_res);
      checkOutput("mdl pc_redirect", {31'b0, pc_redirect}, {31'b0, e_redir});
      checkOutput("mdl flush_front", {31'b0, flush_front}, {31'b0, e_redir});
      checkOutput("mdl target_misaligned", {31'b0, target_misaligned}, {31'b0, e_mis});
      if (e_redir) checkOutput("mdl redirect_target", redirect_target, e_target);
      checkOutput("mdl branch_cnt", {16'b0, branch_cnt}, e_bcnt);
      checkOutput("mdl taken_cnt", {16'b0, taken_cnt}, e_tcnt);
      checkOutput("mdl branch_cnt w2", {30'b0, branch_cnt2}, e_bcnt2);
      checkOutput("mdl taken_cnt w2", {30'b0, taken_cnt2}, e_tcnt2);
      checkOutput("mdl pc_redirect w2", {31'b0, pc_redirect2}, {31'b0, e_redir});
    end
  end

  // Present one EX instruction across a single rising edge, then return
  // 1 time unit after that edge so results can be checked right away.
  task automatic applyStimulus(input logic s, input logic v, input logic b, input logic j,
                               input logic jr, input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] res, input logic [4:0] rd, input logic rw);
    stall = s; ex_valid = v; ex_branch = b; ex_jal = j; ex_jalr = jr;
    ex_pc = pc; ex_imm = imm; ex_result = res; ex_rd = rd; ex_regwrite = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic aluOp(input logic [31:0] res, input logic [4:0] rd);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0, res, rd, 1);
  endtask

  task automatic takenBranch(input logic [31:0] pc, input logic [31:0] imm);
    applyStimulus(0, 1, 1, 0, 0, pc, imm, 32'h1, 5'd0, 1);
  endtask

  task automatic doReset();
    reset = 1;
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    reset = 0;
  endtask

  initial begin
    reset = 1;
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    doReset();
    checkOutput("reset mem_valid", {31'b0, mem_valid}, 32'h0);
    checkOutput("reset mem_result", mem_result, 32'h0);
    checkOutput("reset pc_redirect", {31'b0, pc_redirect}, 32'h0);
    checkOutput("reset taken_cnt", {16'b0, taken_cnt}, 32'h0);

    // Plain ALU op passes straight through.
    aluOp(32'h1234, 5'd5);
    checkOutput("alu mem_valid", {31'b0, mem_valid}, 32'h1);
    checkOutput("alu mem_result", mem_result, 32'h1234);
    checkOutput("alu mem_rd", {27'b0, mem_rd}, 32'd5);
    checkOutput("alu pc_redirect", {31'b0, pc_redirect}, 32'h0);

    // Taken branch, then two dropped instructions, then a survivor.
    takenBranch(32'h100, 32'h20);
    checkOutput("br pc_redirect", {31'b0, pc_redirect}, 32'h1);
    checkOutput("br flush_front", {31'b0, flush_front}, 32'h1);
    checkOutput("br target", redirect_target, 32'h120);
    checkOutput("br mem_regwrite", {31'b0, mem_regwrite}, 32'h0);
    checkOutput("br branch_cnt", {16'b0, branch_cnt}, 32'd1);
    checkOutput("br taken_cnt", {16'b0, taken_cnt}, 32'd1);
    aluOp(32'h11, 5'd2);
    checkOutput("sq1 pc_redirect", {31'b0, pc_redirect}, 32'h0);
    checkOutput("sq1 mem_valid", {31'b0, mem_valid}, 32'h0);
    aluOp(32'h22, 5'd3);
    checkOutput("sq2 mem_valid", {31'b0, mem_valid}, 32'h0);
    aluOp(32'h55, 5'd4);
    checkOutput("pass mem_valid", {31'b0, mem_valid}, 32'h1);
    checkOutput("pass mem_result", mem_result, 32'h55);

    // Not-taken branch, then an all-ones result which must count as taken.
    applyStimulus(0, 1, 1, 0, 0, 32'h180, 32'h40, 32'h0, 5'd6, 1);
    checkOutput("nt pc_redirect", {31'b0, pc_redirect}, 32'h0);
    checkOutput("nt branch_cnt", {16'b0, branch_cnt}, 32'd2);
    checkOutput("nt taken_cnt", {16'b0, taken_cnt}, 32'd1);
    checkOutput("nt mem_regwrite", {31'b0, mem_regwrite}, 32'h0);
    applyStimulus(0, 1, 1, 0, 0, 32'h200, 32'h40, 32'hFFFF_FFFF, 5'd6, 1);
    checkOutput("bne pc_redirect", {31'b0, pc_redirect}, 32'h1);
    checkOutput("bne target", redirect_target, 32'h240);
    aluOp(32'h1, 5'd1);
    aluOp(32'h2, 5'd1);

    // JALR with odd result: bit0 cleared, still misaligned; link = pc+4.
    applyStimulus(0, 1, 0, 0, 1, 32'h40, 32'h0, 32'h203, 5'd1, 1);
    checkOutput("jalr target", redirect_target, 32'h202);
    checkOutput("jalr misaligned", {31'b0, target_misaligned}, 32'h1);
    checkOutput("jalr mem_result", mem_result, 32'h44);
    aluOp(32'h1, 5'd1);
    aluOp(32'h2, 5'd1);
    // JAL whose target and link both wrap around 2^32.
    applyStimulus(0, 1, 0, 1, 0, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd1, 1);
    checkOutput("jal target", redirect_target, 32'h4);
    checkOutput("jal misaligned", {31'b0, target_misaligned}, 32'h0);
    checkOutput("jal mem_result", mem_result, 32'h0);
    aluOp(32'h1, 5'd1);
    aluOp(32'h2, 5'd1);
    aluOp(32'h77, 5'd7);

    // Taken branch held under stall: no redirect, MEM frozen.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 32'h300, 32'h10, 32'h1, 5'd0, 0);
      checkOutput("stall pc_redirect", {31'b0, pc_redirect}, 32'h0);
      checkOutput("stall mem_result", mem_result, 32'h77);
      checkOutput("stall mem_valid", {31'b0, mem_valid}, 32'h1);
    end
    takenBranch(32'h300, 32'h10);
    checkOutput("unstall pc_redirect", {31'b0, pc_redirect}, 32'h1);
    checkOutput("unstall target", redirect_target, 32'h310);
    aluOp(32'h9, 5'd9);
    // Reset in the middle of the squash window.
    doReset();
    checkOutput("midrst mem_valid", {31'b0, mem_valid}, 32'h0);
    checkOutput("midrst branch_cnt", {16'b0, branch_cnt}, 32'h0);
    takenBranch(32'h400, 32'h4);
    checkOutput("postrst pc_redirect", {31'b0, pc_redirect}, 32'h1);
    checkOutput("postrst target", redirect_target, 32'h404);
    checkOutput("postrst taken_cnt", {16'b0, taken_cnt}, 32'd1);
    aluOp(32'h1, 5'd1);
    aluOp(32'h2, 5'd1);

    // Saturation of the 2-bit instance after five spaced taken branches.
    doReset();
    for (int i = 0; i < 5; i++) begin
      takenBranch(32'h500, 32'h8);
      aluOp(32'h1, 5'd1);
      aluOp(32'h2, 5'd1);
    end
    checkOutput("sat taken_cnt w2", {30'b0, taken_cnt2}, 32'd3);
    checkOutput("sat branch_cnt w2", {30'b0, branch_cnt2}, 32'd3);
    checkOutput("sat taken_cnt w16", {16'b0, taken_cnt}, 32'd5);

    // Randomized traffic, including illegal control combinations,
    // bubbles inside squash windows and the odd reset.
    for (int i = 0; i < 3000; i++) begin
      logic        s, v, b, j, jr;
      logic [31:0] res;
      int          r;
      reset = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 7);
      b = (r < 3); j = (r == 3); jr = (r == 4);
      if (r == 5) begin
        b = 1'($urandom); j = 1'($urandom); jr = 1'($urandom);
      end
      case ($urandom_range(0, 3))
        0: res = 32'h0;
        1: res = 32'hFFFF_FFFF;
        default: res = $urandom;
      endcase
      applyStimulus(s, v, b, j, jr, $urandom, $urandom_range(0, 255) - 128,
                    res, 5'($urandom), 1'($urandom));
    end
    reset = 0;
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
